z80_rom_ctrl: RTL and testbench

Bus-side controller that sits between the Z80 CPU bus and the synchronous `rom` block. It decodes CPU memory reads that fall in a fixed address window and drives the ROM's `ena`/`addr` inputs. Because the ROM returns data one clock after `ena`, it stretches the CPU cycle with `cpu_wait_n`, plus a configurable number of extra wait states. It captures `rom_dout` and drives it onto the CPU read-data path until the CPU ends the cycle.

---
 rtl/z80_rom_ctrl_if.sv | 28 ++
 rtl/z80_rom_ctrl.sv | 122 ++++++++++++
 tb/tb_z80_rom_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_rom_ctrl_if.sv
// Bus bundle between the Z80 CPU side, the controller and the synchronous ROM.
// The controller connects through the slave modport. The environment (CPU and ROM)
// connects through the master modport.
interface z80_rom_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic [15:0]       cpu_addr;
  logic              cpu_mreq_n;
  logic              cpu_rd_n;
  logic              cpu_wr_n;
  logic              cpu_wait_n;
  logic [7:0]        cpu_dout;
  logic              cpu_dout_oe;
  logic              rom_ena;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_dout;
  logic              wr_err;

  modport slave (
    input  cpu_addr, cpu_mreq_n, cpu_rd_n, cpu_wr_n, rom_dout,
    output cpu_wait_n, cpu_dout, cpu_dout_oe, rom_ena, rom_addr, wr_err
  );

  modport master (
    output cpu_addr, cpu_mreq_n, cpu_rd_n, cpu_wr_n, rom_dout,
    input  cpu_wait_n, cpu_dout, cpu_dout_oe, rom_ena, rom_addr, wr_err
  );
endinterface

// File: rtl/z80_rom_ctrl.sv
// Z80 bus to synchronous ROM read controller.
// It decodes reads in a fixed window and strobes the ROM with the live CPU address.
// It stalls the CPU through the one-cycle ROM latency plus optional wait states.
// It then holds the captured byte on the read path until the strobe is released.
// Writes into the window raise a single-cycle wr_err pulse.
module z80_rom_ctrl #(
  parameter int          ADDR_W      = 14,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst_n,
  z80_rom_ctrl_if.slave  bus
);

  if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
    $fatal(1, "z80_rom_ctrl: ADDR_W must be 1..16");
  end
  if ((32'(BASE_ADDR) % (32'd1 << ADDR_W)) != 0) begin : g_bad_base
    $fatal(1, "z80_rom_ctrl: BASE_ADDR not aligned to the window size");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $fatal(1, "z80_rom_ctrl: WAIT_STATES must be 0..15");
  end

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [7:0]        data_q;
  logic              wreq_q;
  logic [ADDR_W-1:0] addr_q;

  logic hit, req, wreq;

  // With ADDR_W = 16 both shifts yield zero, so every address hits.
  assign hit  = ((bus.cpu_addr >> ADDR_W) == (BASE_ADDR >> ADDR_W));
  assign req  = hit & ~bus.cpu_mreq_n & ~bus.cpu_rd_n;
  assign wreq = hit & ~bus.cpu_mreq_n & ~bus.cpu_wr_n;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. Any cycle without req sends the access back to idle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (WAIT_STATES == 0) begin
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = WS_LOAD;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!req) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ROM output is valid during FETCH. Latch it as the CPU read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
    end else if (state == S_FETCH) begin
      data_q <= bus.rom_dout;
    end
  end

  // Registered copy of the write request, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreq_q <= 1'b0;
    end else begin
      wreq_q <= wreq;
    end
  end

  // Track the CPU address while idle, so the ROM address freezes once an access starts.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) addr_q <= bus.cpu_addr[ADDR_W-1:0];
  end

  // The bus-facing outputs are combinational. Gating with rst_n forces reset values at once.
  assign bus.rom_ena     = rst_n & req & (state == S_IDLE);
  assign bus.rom_addr    = (state == S_IDLE) ? bus.cpu_addr[ADDR_W-1:0] : addr_q;
  assign bus.cpu_wait_n  = ~(rst_n & req & (state != S_HOLD));
  assign bus.cpu_dout_oe = rst_n & req & (state == S_HOLD);
  assign bus.cpu_dout    = data_q;
  assign bus.wr_err      = rst_n & wreq & ~wreq_q;

endmodule

// File: tb/tb_z80_rom_ctrl.sv
// Bench for z80_rom_ctrl. Two controllers share one CPU bus:
// dut_a uses window 0000-3FFF with no wait states.
// dut_b uses window 4000-7FFF with 3 wait states.
// Each controller has a behavioural ROM. A per-access cycle-count model predicts all outputs.
module tb_z80_rom_ctrl;
  localparam int AW = 14;
  localparam logic [15:0] BASES [2] = '{16'h0000, 16'h4000};
  localparam int          WSS   [2] = '{0, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0123;
  logic        mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;

  always #5 clk = ~clk;

  z80_rom_ctrl_if #(.ADDR_W(AW)) bus_a ();
  z80_rom_ctrl_if #(.ADDR_W(AW)) bus_b ();

  assign bus_a.cpu_addr = addr;   assign bus_b.cpu_addr = addr;
  assign bus_a.cpu_mreq_n = mreq_n; assign bus_b.cpu_mreq_n = mreq_n;
  assign bus_a.cpu_rd_n = rd_n;   assign bus_b.cpu_rd_n = rd_n;
  assign bus_a.cpu_wr_n = wr_n;   assign bus_b.cpu_wr_n = wr_n;

  z80_rom_ctrl #(.ADDR_W(AW), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  z80_rom_ctrl #(.ADDR_W(AW), .BASE_ADDR(16'h4000), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  function automatic logic [7:0] rom_f(logic [13:0] a);
    if (a == 14'h0123) return 8'hA5;
    return a[7:0] ^ {a[13:8], 2'b11};
  endfunction

  // Synchronous ROMs: data appears the cycle after ena.
  always @(posedge clk) if (bus_a.rom_ena) bus_a.rom_dout <= rom_f(bus_a.rom_addr);
  always @(posedge clk) if (bus_b.rom_ena) bus_b.rom_dout <= rom_f(bus_b.rom_addr);

  logic          o_wn [2], o_oe [2], o_ena [2], o_we [2];
  logic [7:0]    o_dout [2];
  logic [AW-1:0] o_ra [2];
  assign o_wn[0] = bus_a.cpu_wait_n;  assign o_wn[1] = bus_b.cpu_wait_n;
  assign o_oe[0] = bus_a.cpu_dout_oe; assign o_oe[1] = bus_b.cpu_dout_oe;
  assign o_ena[0] = bus_a.rom_ena;    assign o_ena[1] = bus_b.rom_ena;
  assign o_we[0] = bus_a.wr_err;      assign o_we[1] = bus_b.wr_err;
  assign o_dout[0] = bus_a.cpu_dout;  assign o_dout[1] = bus_b.cpu_dout;
  assign o_ra[0] = bus_a.rom_addr;    assign o_ra[1] = bus_b.rom_addr;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state per controller.
  // n counts consecutive earlier cycles with req high (0 = idle).
  // lat holds the address of the current access. dm holds the byte presented to the CPU.
  int            m_n  [2] = '{0, 0};
  logic [AW-1:0] m_lat[2];
  logic [7:0]    m_dm [2] = '{8'h00, 8'h00};
  logic          m_wp [2] = '{1'b0, 1'b0};

  // Compare every output of both controllers with the model once per cycle.
  always @(negedge clk) begin
    logic          hit, req, wreq, idle;
    logic          e_wn, e_oe, e_ena, e_we;
    logic [7:0]    e_dout;
    logic [AW-1:0] e_ra;
    for (int d = 0; d < 2; d++) begin
      hit  = ((addr >> AW) == (BASES[d] >> AW));
      req  = hit && !mreq_n && !rd_n;
      wreq = hit && !mreq_n && !wr_n;
      idle = (m_n[d] == 0);
      if (!rst_n) begin
        e_wn = 1'b1; e_oe = 1'b0; e_ena = 1'b0; e_we = 1'b0;
        e_dout = 8'h00; e_ra = addr[AW-1:0];
      end else begin
        e_ena  = req && idle;
        e_ra   = idle ? addr[AW-1:0] : m_lat[d];
        e_wn   = !(req && (m_n[d] < 2 + WSS[d]));
        e_oe   = req && (m_n[d] >= 2 + WSS[d]);
        e_dout = m_dm[d];
        e_we   = wreq && !m_wp[d];
      end
      chk($sformatf("m%0d.wait_n", d), 16'(o_wn[d]), 16'(e_wn));
      chk($sformatf("m%0d.dout_oe", d), 16'(o_oe[d]), 16'(e_oe));
      chk($sformatf("m%0d.rom_ena", d), 16'(o_ena[d]), 16'(e_ena));
      chk($sformatf("m%0d.rom_addr", d), 16'(o_ra[d]), 16'(e_ra));
      chk($sformatf("m%0d.dout", d), 16'(o_dout[d]), 16'(e_dout));
      chk($sformatf("m%0d.wr_err", d), 16'(o_we[d]), 16'(e_we));
      if (!rst_n) begin
        m_n[d] = 0; m_dm[d] = 8'h00; m_wp[d] = 1'b0;
      end else begin
        if (m_n[d] == 1) m_dm[d] = rom_f(m_lat[d]);
        if (idle && req) m_lat[d] = addr[AW-1:0];
        m_n[d] = req ? ((m_n[d] < 1000) ? m_n[d] + 1 : m_n[d]) : 0;
        m_wp[d] = wreq;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    // Reset with a read strobe already on the bus.
    mreq_n = 1'b0; rd_n = 1'b0; addr = 16'h0123;
    @(negedge clk);
    chk("rst.a.wait_n", 16'(bus_a.cpu_wait_n), 16'h1);
    chk("rst.a.rom_ena", 16'(bus_a.rom_ena), 16'h0);
    chk("rst.a.rom_addr", 16'(bus_a.rom_addr), 16'h0123);
    chk("rst.a.dout_oe", 16'(bus_a.cpu_dout_oe), 16'h0);
    chk("rst.b.dout", 16'(bus_b.cpu_dout), 16'h00);
    chk("rst.b.wr_err", 16'(bus_b.wr_err), 16'h0);
    step(); idle_bus(); rst_n = 1'b1;
    step();

    // Read 0x0123 on dut_a (no wait states).
    addr = 16'h0123; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk("rd0.c0.rom_ena", 16'(bus_a.rom_ena), 16'h1);
    chk("rd0.c0.rom_addr", 16'(bus_a.rom_addr), 16'h0123);
    chk("rd0.c0.wait_n", 16'(bus_a.cpu_wait_n), 16'h0);
    chk("rd0.c0.b_ena", 16'(bus_b.rom_ena), 16'h0);
    step(); @(negedge clk);
    chk("rd0.c1.wait_n", 16'(bus_a.cpu_wait_n), 16'h0);
    step(); @(negedge clk);
    chk("rd0.c2.wait_n", 16'(bus_a.cpu_wait_n), 16'h1);
    chk("rd0.c2.dout_oe", 16'(bus_a.cpu_dout_oe), 16'h1);
    chk("rd0.c2.dout", 16'(bus_a.cpu_dout), 16'h00A5);
    step(); rd_n = 1'b1; mreq_n = 1'b1;
    @(negedge clk);
    chk("rd0.release.dout_oe", 16'(bus_a.cpu_dout_oe), 16'h0);
    step();

    // Read 0x4000 on dut_b (3 wait states). dut_a must ignore it.
    addr = 16'h4000; mreq_n = 1'b0; rd_n = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!bus_b.cpu_wait_n) cnt_b++;
      if (bus_a.rom_ena) cnt_a++;
      step();
    end
    @(negedge clk);
    chk("rd3.wait_cycles", 16'(cnt_b), 16'd5);
    chk("rd3.a_ena", 16'(cnt_a), 16'd0);
    chk("rd3.dout_oe", 16'(bus_b.cpu_dout_oe), 16'h1);
    chk("rd3.dout", 16'(bus_b.cpu_dout), 16'h0003);
    step(); rd_n = 1'b1;
    @(negedge clk);
    chk("rd3.release.dout_oe", 16'(bus_b.cpu_dout_oe), 16'h0);
    step(); idle_bus(); step();

    // Read 0x3FFF: dut_a's window only.
    addr = 16'h3FFF; mreq_n = 1'b0; rd_n = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_b.rom_ena) cnt_a++;
      if (!bus_b.cpu_wait_n) cnt_b++;
      step();
    end
    chk("win.3fff.b_ena", 16'(cnt_a), 16'd0);
    chk("win.3fff.b_wait", 16'(cnt_b), 16'd0);
    idle_bus(); step();

    // Abort dut_b during WAIT, then do a clean read.
    addr = 16'h4100; mreq_n = 1'b0; rd_n = 1'b0;
    cnt_c = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (bus_b.cpu_dout_oe) cnt_c++; step();
    end
    mreq_n = 1'b1;
    @(negedge clk);
    chk("abort.wait_n", 16'(bus_b.cpu_wait_n), 16'h1);
    chk("abort.oe_seen", 16'(cnt_c), 16'd0);
    step(); step();
    addr = 16'h4005; mreq_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    chk("abort.next.dout_oe", 16'(bus_b.cpu_dout_oe), 16'h1);
    chk("abort.next.dout", 16'(bus_b.cpu_dout), 16'h0006);
    step(); idle_bus(); step();

    // Three-cycle write strobe into dut_b's window.
    addr = 16'h4010; mreq_n = 1'b0; wr_n = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_b.wr_err) cnt_a++;
      if (bus_b.rom_ena) cnt_b++;
      if (!bus_b.cpu_wait_n) cnt_c++;
      step();
    end
    chk("wr.pulses", 16'(cnt_a), 16'd1);
    chk("wr.rom_ena", 16'(cnt_b), 16'd0);
    chk("wr.wait", 16'(cnt_c), 16'd0);
    idle_bus(); step();

    // Strobe held for 10 cycles on dut_a, then reset while in HOLD.
    addr = 16'h0010; mreq_n = 1'b0; rd_n = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (bus_a.rom_ena) cnt_a++; step();
    end
    chk("held.ena_pulses", 16'(cnt_a), 16'd1);
    chk("held.dout", 16'(bus_a.cpu_dout), 16'h0013);
    rst_n = 1'b0;
    #1;
    chk("held.rst.dout_oe", 16'(bus_a.cpu_dout_oe), 16'h0);
    chk("held.rst.wait_n", 16'(bus_a.cpu_wait_n), 16'h1);
    chk("held.rst.dout", 16'(bus_a.cpu_dout), 16'h00);
    step(); idle_bus(); step(); rst_n = 1'b1; step();

    // Random bus cycles against the model.
    for (int t = 0; t < 400; t++) begin
      int kind, len;
      case ($urandom_range(0, 5))
        0: addr = 16'($urandom_range(0, 16'h3FFF));
        1: addr = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
        2: addr = 16'h3FFF;
        3: addr = 16'h4000;
        4: addr = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: addr = 16'($urandom);
      endcase
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 10);
      mreq_n = (kind == 9);
      rd_n   = !(kind < 6 || kind == 8);
      wr_n   = !(kind >= 6);
      for (int i = 0; i < len; i++) begin
        step();
        if ($urandom_range(0, 19) == 0) addr = 16'($urandom);
        if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
      end
      if ($urandom_range(0, 2) != 0) begin
        idle_bus();
        repeat ($urandom_range(1, 2)) step();
      end
    end
    idle_bus(); rst_n = 1'b1;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
